uart_tx_pkt_arbiter: RTL and testbench

UART_TX_PKT_ARBITER -- requirements
Module: uart_tx_pkt_arbiter

---
 rtl/uart_tx_pkt_arbiter_pkg.sv | 18 +
 rtl/uart_tx_pkt_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_pkt_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_pkt_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkt_arbiter_pkg.sv
// Shared definitions for the packet arbiter that feeds a uart_tx.
// Holds the FSM encoding and a width helper for counters.
package uart_tx_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_of(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_pkt_arbiter_rr_pick.sv
// Round-robin search: first set request bit after ptr, wrapping at NUM_SRC.
// Purely combinational.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  localparam logic [IDX_W:0]   N_W  = (IDX_W + 1)'(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SRC - 1);

  logic [IDX_W-1:0] start;
  logic [IDX_W:0]   cand;

  assign start = (ptr == LAST) ? '0 : ptr + 1'b1;

  // Scan farthest-first so the nearest requester is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, start} + (IDX_W + 1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req[cand[IDX_W-1:0]]) begin
        idx   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_pkt_arbiter.sv
// Packet-level round-robin arbiter muxing NUM_SRC beat streams onto one
// uart_tx input; a grant lasts a whole packet, optionally followed by idle gap.
module uart_tx_pkt_arbiter
  import uart_tx_pkt_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int Word_len   = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC*Word_len-1:0]  s_data,
  input  logic [NUM_SRC-1:0]           s_valid,
  input  logic [NUM_SRC-1:0]           s_last,
  output logic [NUM_SRC-1:0]           s_ready,
  input  logic [NUM_SRC-1:0]           src_en,
  output logic [Word_len-1:0]          m_data,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int GAP_W = width_of(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_SRC - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [NUM_SRC-1:0] req;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [Word_len-1:0] src_data [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = s_data[gi*Word_len +: Word_len];
    end
  endgenerate

  // The enable mask only gates who may win; it never affects an active grant.
  assign req = s_valid & src_en;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= PTR_RST;
      grant_reg   <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    gap_cnt_next = gap_cnt_reg;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    m_data       = '0;
    s_ready      = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          ptr_next   = pick_idx;
          state_next = XFER;
        end
      end
      XFER: begin
        m_valid            = s_valid[grant_reg];
        m_last             = s_last[grant_reg];
        m_data             = src_data[grant_reg];
        s_ready[grant_reg] = m_ready;
        if (s_valid[grant_reg] && m_ready && s_last[grant_reg]) begin
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            gap_cnt_next = '0;
            state_next   = GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg + 1'b1;
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_idx = grant_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_pkt_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// against a packet-level round-robin model.
module tb_uart_tx_pkt_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_valid, s_last, s_ready, src_en;
  logic [W-1:0]   m_data;
  logic           m_valid, m_last, m_ready;
  logic [1:0]     grant_idx;
  logic           busy;

  uart_tx_pkt_arbiter #(.NUM_SRC(N), .Word_len(W), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .src_en(src_en), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .grant_idx(grant_idx), .busy(busy)
  );

  logic [15:0] g_s_data;
  logic [1:0]  g_s_valid, g_s_last, g_s_ready, g_src_en;
  logic [7:0]  g_m_data;
  logic        g_m_valid, g_m_last, g_m_ready;
  logic [0:0]  g_grant;
  logic        g_busy;

  uart_tx_pkt_arbiter #(.NUM_SRC(2), .Word_len(8), .GAP_CYCLES(5)) dut_gap (
    .clk(clk), .rst(rst), .s_data(g_s_data), .s_valid(g_s_valid), .s_last(g_s_last),
    .s_ready(g_s_ready), .src_en(g_src_en), .m_data(g_m_data), .m_valid(g_m_valid),
    .m_last(g_m_last), .m_ready(g_m_ready), .grant_idx(g_grant), .busy(g_busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] sb_data [N][16];
  bit         sb_last [N][16];
  int         sb_len [N];
  int         sb_pos [N];

  logic [7:0] obs_data [64];
  int         obs_src [64];
  bit         obs_last [64];
  int         n_obs;

  logic [7:0] exp_data [64];
  int         exp_src [64];
  bit         exp_last [64];
  int         n_exp;

  logic       snap_mvalid, snap_mlast, snap_busy;
  logic [7:0] snap_mdata;
  logic [3:0] snap_sready;
  logic [1:0] snap_grant;

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      sb_len[i] = 0;
      sb_pos[i] = 0;
    end
  endtask

  task automatic add_packet(input int src, input int len, input logic [7:0] first);
    for (int k = 0; k < len; k++) begin
      sb_data[src][sb_len[src]] = 8'(first + k);
      sb_last[src][sb_len[src]] = (k == len - 1);
      sb_len[src]++;
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (sb_pos[i] < sb_len[i]) begin
        s_valid[i]       = 1'b1;
        s_data[i*W +: W] = sb_data[i][sb_pos[i]];
        s_last[i]        = sb_last[i][sb_pos[i]];
      end else begin
        s_valid[i]       = 1'b0;
        s_data[i*W +: W] = '0;
        s_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock of source driving and output monitoring (no checking here).
  task automatic step();
    drive_sources();
    @(negedge clk);
    snap_mvalid = m_valid;
    snap_mlast  = m_last;
    snap_mdata  = m_data;
    snap_busy   = busy;
    snap_sready = s_ready;
    snap_grant  = grant_idx;
    if (m_valid && m_ready && n_obs < 64) begin
      obs_data[n_obs] = m_data;
      obs_src[n_obs]  = int'(grant_idx);
      obs_last[n_obs] = m_last;
      n_obs++;
    end
    for (int i = 0; i < N; i++) begin
      if (s_ready[i] && s_valid[i]) sb_pos[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) begin
      if (sb_pos[i] < sb_len[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_traffic(input int max_cycles, input bit rand_ready);
    int cyc;
    cyc = 0;
    while (pending() && cyc < max_cycles) begin
      m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      cyc++;
    end
    m_ready = 1'b1;
  endtask

  // Reference: whole packets granted round-robin from the pointer, which
  // starts at the top index after reset; all loaded sources keep requesting.
  task automatic build_expected();
    int pos [N];
    int ptr;
    bit found;
    for (int i = 0; i < N; i++) pos[i] = sb_pos[i];
    ptr = N - 1;
    n_exp = 0;
    do begin
      found = 1'b0;
      for (int k = 1; k <= N && !found; k++) begin
        if (pos[(ptr + k) % N] < sb_len[(ptr + k) % N]) begin
          found = 1'b1;
          ptr = (ptr + k) % N;
        end
      end
      if (found) begin
        do begin
          exp_data[n_exp] = sb_data[ptr][pos[ptr]];
          exp_last[n_exp] = sb_last[ptr][pos[ptr]];
          exp_src[n_exp]  = ptr;
          pos[ptr]++;
          n_exp++;
        end while (!exp_last[n_exp-1] && n_exp < 64);
      end
    end while (found && n_exp < 64);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sources();
    m_ready = 1'b1;
    src_en = '1;
    drive_sources();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_obs = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_sources();
    m_ready = 1'b1;
    src_en = '1;
    drive_sources();
    g_s_valid = '0; g_s_last = '0; g_s_data = '0; g_src_en = '1; g_m_ready = 1'b1;
    #2;
    tests_run++;
    if ({m_valid, m_last, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: m_valid/m_last/busy=%b expected 000", {m_valid, m_last, busy});
    end
    tests_run++;
    if ({m_data, s_ready, grant_idx} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_data: m_data=%h s_ready=%b grant=%0d expected all zero", m_data, s_ready, grant_idx);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    add_packet(2, 3, 8'h41);
    step();
    tests_run++;
    if ({snap_busy, snap_mvalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_arb_cycle: busy/m_valid=%b expected 00", {snap_busy, snap_mvalid});
    end
    for (int b = 0; b < 3; b++) begin
      step();
      tests_run++;
      if (snap_grant !== 2'd2 || snap_mvalid !== 1'b1 || snap_mdata !== 8'(8'h41 + b) ||
          snap_mlast !== (b == 2) || snap_sready !== 4'b0100) begin
        tests_failed++;
        $display("FAIL single_beat%0d: grant=%0d valid=%b data=%h last=%b s_ready=%b expected 2 1 %h %b 0100",
                 b, snap_grant, snap_mvalid, snap_mdata, snap_mlast, snap_sready, 8'(8'h41 + b), (b == 2));
      end
    end
    step();
    tests_run++;
    if (snap_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_fall: busy=%b expected 0", snap_busy);
    end
  endtask

  task automatic test_contention();
    do_reset();
    add_packet(0, 2, 8'h00);
    add_packet(1, 2, 8'h10);
    add_packet(3, 2, 8'h30);
    add_packet(0, 2, 8'h08);
    build_expected();
    run_traffic(200, 1'b0);
    tests_run++;
    if (n_obs !== n_exp) begin
      tests_failed++;
      $display("FAIL contention_count: beats=%0d expected %0d", n_obs, n_exp);
    end
    for (int b = 0; b < n_obs && b < n_exp; b++) begin
      tests_run++;
      if (obs_data[b] !== exp_data[b] || obs_src[b] !== exp_src[b] || obs_last[b] !== exp_last[b]) begin
        tests_failed++;
        $display("FAIL contention_beat%0d: data=%h src=%0d last=%b expected %h %0d %b",
                 b, obs_data[b], obs_src[b], obs_last[b], exp_data[b], exp_src[b], exp_last[b]);
      end
    end
    tests_run++;
    if (obs_src[0] !== 0 || obs_src[2] !== 1 || obs_src[4] !== 3 || obs_src[6] !== 0) begin
      tests_failed++;
      $display("FAIL contention_order: %0d,%0d,%0d,%0d expected 0,1,3,0",
               obs_src[0], obs_src[2], obs_src[4], obs_src[6]);
    end
  endtask

  task automatic test_backpressure();
    int pat [7] = '{1, 1, 0, 0, 1, 1, 1};
    int idx;
    logic [7:0] prev;
    bit prev_stall;
    do_reset();
    add_packet(1, 4, 8'h60);
    idx = 0;
    prev = '0;
    prev_stall = 1'b0;
    for (int c = 0; c < 7; c++) begin
      m_ready = pat[c][0];
      step();
      if (c > 0) begin
        tests_run++;
        if (snap_mvalid !== 1'b1 || snap_mdata !== 8'(8'h60 + idx) || snap_sready !== {2'b00, m_ready, 1'b0}) begin
          tests_failed++;
          $display("FAIL bp_cycle%0d: valid=%b data=%h s_ready=%b expected 1 %h %b",
                   c, snap_mvalid, snap_mdata, snap_sready, 8'(8'h60 + idx), {2'b00, m_ready, 1'b0});
        end
        if (prev_stall) begin
          tests_run++;
          if (snap_mdata !== prev) begin
            tests_failed++;
            $display("FAIL bp_stable%0d: data=%h expected %h", c, snap_mdata, prev);
          end
        end
        prev = snap_mdata;
        prev_stall = (pat[c] == 0);
        if (pat[c] != 0) idx++;
      end
    end
    m_ready = 1'b1;
    tests_run++;
    if (n_obs !== 4 || sb_pos[1] !== 4) begin
      tests_failed++;
      $display("FAIL bp_count: beats=%0d consumed=%0d expected 4 4", n_obs, sb_pos[1]);
    end
  endtask

  task automatic test_mask();
    do_reset();
    add_packet(0, 3, 8'hA0);
    add_packet(0, 2, 8'hB0);
    step();
    step();
    src_en = 4'b1110;
    step();
    step();
    tests_run++;
    if (n_obs !== 3 || obs_src[2] !== 0 || obs_last[2] !== 1'b1 || obs_data[2] !== 8'hA2) begin
      tests_failed++;
      $display("FAIL mask_complete: beats=%0d src=%0d last=%b data=%h expected 3 0 1 a2",
               n_obs, obs_src[2], obs_last[2], obs_data[2]);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if ({snap_busy, snap_mvalid} !== 2'b00) begin
        tests_failed++;
        $display("FAIL mask_skip%0d: busy/m_valid=%b expected 00", c, {snap_busy, snap_mvalid});
      end
    end
    add_packet(1, 1, 8'hC5);
    step();
    step();
    tests_run++;
    if (n_obs !== 4 || obs_src[3] !== 1 || obs_data[3] !== 8'hC5) begin
      tests_failed++;
      $display("FAIL mask_next: beats=%0d src=%0d data=%h expected 4 1 c5", n_obs, obs_src[3], obs_data[3]);
    end
    src_en = '1;
    run_traffic(50, 1'b0);
    tests_run++;
    if (n_obs !== 6 || obs_src[4] !== 0 || obs_data[4] !== 8'hB0 || obs_data[5] !== 8'hB1) begin
      tests_failed++;
      $display("FAIL mask_reenable: beats=%0d src=%0d data=%h,%h expected 6 0 b0,b1",
               n_obs, obs_src[4], obs_data[4], obs_data[5]);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    add_packet(2, 3, 8'h20);
    step();
    step();
    drive_sources();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({m_valid, m_last, busy, m_data, s_ready, grant_idx} !== 17'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs: valid=%b last=%b busy=%b data=%h s_ready=%b grant=%0d expected zeros",
               m_valid, m_last, busy, m_data, s_ready, grant_idx);
    end
    sb_pos[2] = 0;
    add_packet(0, 1, 8'h05);
    drive_sources();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_obs = 0;
    run_traffic(100, 1'b0);
    tests_run++;
    if (n_obs !== 4 || obs_src[0] !== 0 || obs_data[0] !== 8'h05) begin
      tests_failed++;
      $display("FAIL abort_first: beats=%0d src=%0d data=%h expected 4 0 05", n_obs, obs_src[0], obs_data[0]);
    end
    for (int b = 1; b < 4 && b < n_obs; b++) begin
      tests_run++;
      if (obs_data[b] !== 8'(8'h20 + b - 1) || obs_src[b] !== 2) begin
        tests_failed++;
        $display("FAIL abort_resend%0d: data=%h src=%0d expected %h 2", b, obs_data[b], obs_src[b], 8'(8'h20 + b - 1));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) add_packet(i, $urandom_range(1, 4), 8'($urandom));
      end
      build_expected();
      run_traffic(600, 1'b1);
      tests_run++;
      if (n_obs !== n_exp) begin
        tests_failed++;
        $display("FAIL random%0d_count: beats=%0d expected %0d", r, n_obs, n_exp);
      end
      for (int b = 0; b < n_obs && b < n_exp; b++) begin
        tests_run++;
        if (obs_data[b] !== exp_data[b] || obs_src[b] !== exp_src[b] || obs_last[b] !== exp_last[b]) begin
          tests_failed++;
          $display("FAIL random%0d_beat%0d: data=%h src=%0d last=%b expected %h %0d %b",
                   r, b, obs_data[b], obs_src[b], obs_last[b], exp_data[b], exp_src[b], exp_last[b]);
        end
      end
    end
  endtask

  task automatic test_gap();
    int xc [4];
    int n, pos, gap_seen;
    do_reset();
    g_src_en = 2'b11;
    g_m_ready = 1'b1;
    n = 0;
    pos = 0;
    gap_seen = 0;
    for (int cyc = 0; cyc < 60 && pos < 4; cyc++) begin
      g_s_valid = 2'b10;
      g_s_data  = {8'(8'h50 + pos), 8'h00};
      g_s_last  = {(pos == 1 || pos == 3), 1'b0};
      @(negedge clk);
      if (g_busy && !g_m_valid) begin
        gap_seen++;
        tests_run++;
        if (g_s_ready !== 2'b00) begin
          tests_failed++;
          $display("FAIL gap_ready: s_ready=%b expected 00", g_s_ready);
        end
      end
      if (g_m_valid && g_m_ready) begin
        tests_run++;
        if (g_m_data !== 8'(8'h50 + pos) || g_grant !== 1'b1) begin
          tests_failed++;
          $display("FAIL gap_beat%0d: data=%h grant=%0d expected %h 1", pos, g_m_data, g_grant, 8'(8'h50 + pos));
        end
        xc[n] = cyc;
        n++;
      end
      if (g_s_ready[1]) pos++;
      @(posedge clk);
      #1;
    end
    g_s_valid = '0;
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL gap_count: beats=%0d expected 4", n);
    end else begin
      tests_run++;
      if (xc[1] - xc[0] !== 1 || xc[2] - xc[1] !== 7 || gap_seen !== 5) begin
        tests_failed++;
        $display("FAIL gap_timing: spacing=%0d/%0d gap_cycles=%0d expected 1/7 5",
                 xc[1] - xc[0], xc[2] - xc[1], gap_seen);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s_data = '0; s_valid = '0; s_last = '0; src_en = '1; m_ready = 1'b1;
    n_obs = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_mask();
    test_reset_abort();
    test_random();
    test_gap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
